// File: rtl/bp_axil_read_arbiter.sv
// ----------------------------------------------------------------------------
// bp_axil_read_arbiter: round-robin sharing of one AXI-Lite AR/R master port
// among num_req_p requesters, with credit-bounded, in-order response routing.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bp_axil_read_arbiter #(
  parameter int num_req_p    = 2,
  parameter int addr_width_p = 64,
  parameter int data_width_p = 32,
  parameter int credits_p    = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,

  input  logic [num_req_p-1:0]              req_v_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  output logic [num_req_p-1:0]              req_ready_and_o,

  output logic [num_req_p-1:0]              resp_v_o,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic                              resp_err_o,
  input  logic [num_req_p-1:0]              resp_ready_and_i,

  output logic [addr_width_p-1:0]           m_axil_araddr,
  output logic                              m_axil_arvalid,
  input  logic                              m_axil_arready,
  output logic [2:0]                        m_axil_arprot,

  input  logic [data_width_p-1:0]           m_axil_rdata,
  input  logic                              m_axil_rvalid,
  output logic                              m_axil_rready,
  input  logic [1:0]                        m_axil_rresp,

  output logic                              spurious_o
);

  localparam int ptr_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w = $clog2(credits_p + 1);
  localparam int tag_w = (credits_p > 1) ? $clog2(credits_p) : 1;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [ptr_w-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0]          id_q, id_d;
  logic [addr_width_p-1:0]   addr_q, addr_d;
  logic [cnt_w-1:0]          outstanding_q;
  logic [ptr_w-1:0]          tag_mem_q [credits_p];
  logic [tag_w-1:0]          wr_ptr_q, rd_ptr_q;
  logic                      spurious_q;

  logic                      found;
  logic [ptr_w-1:0]          winner;
  logic                      ar_hs, pop, fifo_empty;
  logic [ptr_w-1:0]          head;
  int                        idx;

  function automatic logic [tag_w-1:0] tag_inc(input logic [tag_w-1:0] p);
    return (p == tag_w'(credits_p - 1)) ? '0 : p + tag_w'(1);
  endfunction

  // Cyclic first-set search starting at the round-robin pointer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && req_v_i[idx]) begin
        found  = 1'b1;
        winner = ptr_w'(idx);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    addr_d          = addr_q;
    id_d            = id_q;
    req_ready_and_o = '0;
    m_axil_arvalid  = 1'b0;
    case (state_q)
      e_idle: begin
        if (!reset_i && found && (outstanding_q < cnt_w'(credits_p))) begin
          req_ready_and_o[winner] = 1'b1;
          addr_d   = req_addr_i[winner*addr_width_p +: addr_width_p];
          id_d     = winner;
          rr_ptr_d = (winner == ptr_w'(num_req_p - 1)) ? '0 : winner + ptr_w'(1);
          state_d  = e_send;
        end
      end
      e_send: begin
        m_axil_arvalid = 1'b1;
        if (m_axil_arready) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  assign m_axil_araddr = addr_q;
  assign m_axil_arprot = 3'b000;
  assign ar_hs         = (state_q == e_send) && m_axil_arready;

  // The tag FIFO occupancy doubles as the outstanding-read credit count.
  assign fifo_empty = (outstanding_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  always_comb begin
    resp_v_o      = '0;
    m_axil_rready = 1'b1;
    if (!fifo_empty) begin
      m_axil_rready  = resp_ready_and_i[head];
      resp_v_o[head] = m_axil_rvalid;
    end
  end

  assign pop         = m_axil_rvalid && m_axil_rready && !fifo_empty;
  assign resp_data_o = m_axil_rdata;
  assign resp_err_o  = m_axil_rvalid && (m_axil_rresp != 2'b00);
  assign spurious_o  = spurious_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_idle;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      addr_q        <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      spurious_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      if (ar_hs) wr_ptr_q <= tag_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= tag_inc(rd_ptr_q);
      case ({ar_hs, pop})
        2'b10:   outstanding_q <= outstanding_q + cnt_w'(1);
        2'b01:   outstanding_q <= outstanding_q - cnt_w'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (m_axil_rvalid && fifo_empty) spurious_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ar_hs) tag_mem_q[wr_ptr_q] <= id_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_axil_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bp_axil_read_arbiter: directed self-checking bench for bp_axil_read_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bp_axil_read_arbiter;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [1:0]   req_v_i;
  logic [127:0] req_addr_i;
  logic [1:0]   req_ready_and_o;
  logic [1:0]   resp_v_o;
  logic [31:0]  resp_data_o;
  logic         resp_err_o;
  logic [1:0]   resp_ready_and_i;
  logic [63:0]  m_axil_araddr;
  logic         m_axil_arvalid;
  logic         m_axil_arready;
  logic [2:0]   m_axil_arprot;
  logic [31:0]  m_axil_rdata;
  logic         m_axil_rvalid;
  logic         m_axil_rready;
  logic [1:0]   m_axil_rresp;
  logic         spurious_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ar_cnt;

  always #5 clk_i = ~clk_i;

  bp_axil_read_arbiter #(
    .num_req_p   (2),
    .addr_width_p(64),
    .data_width_p(32),
    .credits_p   (2)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_v_i         (req_v_i),
    .req_addr_i      (req_addr_i),
    .req_ready_and_o (req_ready_and_o),
    .resp_v_o        (resp_v_o),
    .resp_data_o     (resp_data_o),
    .resp_err_o      (resp_err_o),
    .resp_ready_and_i(resp_ready_and_i),
    .m_axil_araddr   (m_axil_araddr),
    .m_axil_arvalid  (m_axil_arvalid),
    .m_axil_arready  (m_axil_arready),
    .m_axil_arprot   (m_axil_arprot),
    .m_axil_rdata    (m_axil_rdata),
    .m_axil_rvalid   (m_axil_rvalid),
    .m_axil_rready   (m_axil_rready),
    .m_axil_rresp    (m_axil_rresp),
    .spurious_o      (spurious_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    req_v_i          = '0;
    req_addr_i       = '0;
    resp_ready_and_i = 2'b11;
    m_axil_arready   = 1'b0;
    m_axil_rdata     = '0;
    m_axil_rvalid    = 1'b0;
    m_axil_rresp     = 2'b00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    #1;
    check_val("rst_arvalid", m_axil_arvalid, 0);
    check_val("rst_req_ready", req_ready_and_o, 0);
    check_val("rst_resp_v", resp_v_o, 0);
    check_val("rst_rready", m_axil_rready, 1);
    check_val("rst_spurious", spurious_o, 0);
    reset_i = 1'b0;

    // Single request from requester 0
    req_v_i = 2'b01;
    req_addr_i[63:0] = 64'h8;
    #1;
    check_val("t1_grant", req_ready_and_o, 2'b01);
    check_val("t1_arvalid_at_accept", m_axil_arvalid, 0);
    tick();
    req_v_i = 2'b00;
    #1;
    check_val("t1_arvalid", m_axil_arvalid, 1);
    check_val("t1_araddr", m_axil_araddr, 64'h8);
    check_val("t1_arprot", m_axil_arprot, 0);
    m_axil_arready = 1'b1;
    tick();
    m_axil_arready = 1'b0;
    #1;
    check_val("t1_arvalid_drop", m_axil_arvalid, 0);
    check_val("t1_outstanding1", dut.outstanding_q, 1);
    tick();
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h5;
    #1;
    check_val("t1_resp_v", resp_v_o, 2'b01);
    check_val("t1_resp_data", resp_data_o, 32'h5);
    check_val("t1_rready", m_axil_rready, 1);
    check_val("t1_err", resp_err_o, 0);
    tick();
    m_axil_rvalid = 1'b0;
    #1;
    check_val("t1_resp_v_off", resp_v_o, 0);
    check_val("t1_outstanding0", dut.outstanding_q, 0);

    // Round-robin with both requesters always valid
    do_reset();
    req_addr_i[63:0]   = 64'h100;
    req_addr_i[127:64] = 64'h200;
    m_axil_arready = 1'b1;
    for (int g = 0; g <= 6; g++) begin
      if (g > 0) begin
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'hA0 + 32'(g - 1);
      end
      req_v_i = (g < 6) ? 2'b11 : 2'b00;
      #1;
      if (g > 0) begin
        check_val("t2_resp_v", resp_v_o, ((g - 1) % 2 == 0) ? 2'b01 : 2'b10);
        check_val("t2_resp_data", resp_data_o, 32'hA0 + 32'(g - 1));
      end
      check_val("t2_grant", req_ready_and_o,
                (g == 6) ? 2'b00 : ((g % 2 == 0) ? 2'b01 : 2'b10));
      tick();
      m_axil_rvalid = 1'b0;
      if (g < 6) begin
        #1;
        check_val("t2_araddr", m_axil_araddr, (g % 2 == 0) ? 64'h100 : 64'h200);
        tick();
      end
    end
    m_axil_arready = 1'b0;
    #1;
    check_val("t2_outstanding0", dut.outstanding_q, 0);

    // Credit exhaustion: slave accepts ARs but returns no R
    do_reset();
    req_v_i = 2'b01;
    req_addr_i[63:0] = 64'h300;
    m_axil_arready = 1'b1;
    ar_cnt = 0;
    repeat (12) begin
      #1;
      if (m_axil_arvalid && m_axil_arready) ar_cnt++;
      tick();
    end
    #1;
    check_val("t3_ar_count", ar_cnt, 2);
    check_val("t3_no_grant", req_ready_and_o, 0);
    check_val("t3_outstanding2", dut.outstanding_q, 2);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h33;
    #1;
    check_val("t3_resp_v", resp_v_o, 2'b01);
    check_val("t3_no_grant_same_cycle", req_ready_and_o, 0);
    tick();
    m_axil_rvalid = 1'b0;
    #1;
    check_val("t3_grant_after_release", req_ready_and_o, 2'b01);
    ar_cnt = 0;
    repeat (10) begin
      #1;
      if (m_axil_arvalid && m_axil_arready) ar_cnt++;
      tick();
    end
    #1;
    check_val("t3_ar_count_after", ar_cnt, 1);
    check_val("t3_no_grant_again", req_ready_and_o, 0);

    // AR backpressure
    do_reset();
    req_v_i = 2'b01;
    req_addr_i[63:0] = 64'h400;
    #1;
    check_val("t4_grant0", req_ready_and_o, 2'b01);
    tick();
    req_v_i = 2'b10;
    req_addr_i[127:64] = 64'h500;
    repeat (5) begin
      #1;
      check_val("t4_arvalid_hold", m_axil_arvalid, 1);
      check_val("t4_araddr_hold", m_axil_araddr, 64'h400);
      check_val("t4_no_grant", req_ready_and_o, 0);
      tick();
    end
    m_axil_arready = 1'b1;
    tick();
    m_axil_arready = 1'b0;
    #1;
    check_val("t4_grant1", req_ready_and_o, 2'b10);
    tick();
    req_v_i = 2'b00;
    #1;
    check_val("t4_araddr1", m_axil_araddr, 64'h500);

    // Response backpressure: requester 1 first, requester 0 queued behind
    do_reset();
    m_axil_arready = 1'b1;
    req_v_i = 2'b10;
    req_addr_i[127:64] = 64'h600;
    #1;
    check_val("t5_grant1", req_ready_and_o, 2'b10);
    tick();
    req_v_i = 2'b00;
    tick();
    req_v_i = 2'b01;
    req_addr_i[63:0] = 64'h700;
    #1;
    check_val("t5_grant0", req_ready_and_o, 2'b01);
    tick();
    req_v_i = 2'b00;
    tick();
    m_axil_arready = 1'b0;
    #1;
    check_val("t5_outstanding2", dut.outstanding_q, 2);
    resp_ready_and_i = 2'b01;
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h11;
    m_axil_rresp  = 2'b10;
    repeat (3) begin
      #1;
      check_val("t5_rready_low", m_axil_rready, 0);
      check_val("t5_resp_v_req1", resp_v_o, 2'b10);
      check_val("t5_err", resp_err_o, 1);
      tick();
    end
    #1;
    check_val("t5_outstanding_held", dut.outstanding_q, 2);
    resp_ready_and_i = 2'b11;
    #1;
    check_val("t5_rready_high", m_axil_rready, 1);
    tick();
    m_axil_rdata = 32'h22;
    m_axil_rresp = 2'b00;
    #1;
    check_val("t5_resp_v_req0", resp_v_o, 2'b01);
    check_val("t5_err_clear", resp_err_o, 0);
    check_val("t5_data0", resp_data_o, 32'h22);
    tick();
    m_axil_rvalid = 1'b0;
    #1;
    check_val("t5_outstanding0", dut.outstanding_q, 0);

    // Spurious beat, then reset while in e_send
    do_reset();
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'hDEAD;
    #1;
    check_val("t6_rready_empty", m_axil_rready, 1);
    check_val("t6_resp_v_none", resp_v_o, 0);
    tick();
    m_axil_rvalid = 1'b0;
    #1;
    check_val("t6_spurious_set", spurious_o, 1);
    tick();
    #1;
    check_val("t6_spurious_sticky", spurious_o, 1);
    check_val("t6_outstanding0", dut.outstanding_q, 0);
    req_v_i = 2'b01;
    req_addr_i[63:0] = 64'h800;
    tick();
    #1;
    check_val("t6_in_send", m_axil_arvalid, 1);
    reset_i = 1'b1;
    tick();
    #1;
    check_val("t6_rst_arvalid", m_axil_arvalid, 0);
    check_val("t6_rst_req_ready", req_ready_and_o, 0);
    check_val("t6_rst_spurious", spurious_o, 0);
    check_val("t6_rst_rready", m_axil_rready, 1);
    check_val("t6_rst_resp_v", resp_v_o, 0);
    reset_i = 1'b0;
    req_v_i = 2'b00;
    tick();
    #1;
    check_val("t6_post_arvalid", m_axil_arvalid, 0);
    check_val("t6_post_outstanding", dut.outstanding_q, 0);
    check_val("t6_post_rr_ptr", dut.rr_ptr_q, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
